// File: rtl/gifplayer_frame_sequencer_pkg.sv
// Shared constants for the GIF frame sequencer: details-RAM word map, FSM encodings
// and the fallback frame delay.
package gifplayer_frame_sequencer_pkg;

    localparam logic [1:0] DET_WIDTH  = 2'd0;
    localparam logic [1:0] DET_HEIGHT = 2'd1;
    localparam logic [1:0] DET_DELAY  = 2'd2;
    localparam logic [1:0] DET_COUNT  = 2'd3;

    localparam int DEFAULT_CS = 10;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_FETCH      = 3'd1;
    localparam state_t ST_CALC       = 3'd2;
    localparam state_t ST_RUN        = 3'd3;
    localparam state_t ST_WAIT_VSYNC = 3'd4;
    localparam state_t ST_ADVANCE    = 3'd5;

    // GIF encoders write 0 for "as fast as possible"; play those at a sane rate instead.
    function automatic logic [15:0] delay_or_default(input logic [15:0] raw,
                                                     input logic [15:0] dflt);
        return (raw == 16'd0) ? dflt : raw;
    endfunction

endpackage

// File: rtl/gifplayer_frame_sequencer_if.sv
// Read-only port onto the 4x16 image-details RAM (address, select, 1-cycle read data).
interface gifplayer_frame_sequencer_if;

    logic [1:0]  det_address;
    logic        det_chipselect;
    logic [15:0] det_readdata;

    modport master (
        output det_address,
        output det_chipselect,
        input  det_readdata
    );

    modport slave (
        input  det_address,
        input  det_chipselect,
        output det_readdata
    );

endinterface

// File: rtl/gifplayer_frame_sequencer_cs_tick.sv
// Centisecond prescaler: one-cycle tick every TICK_DIV cycles, restarted by clear.
module gifplayer_cs_tick #(
    parameter int TICK_DIV = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] pre_reg;

    assign tick = !clear && (pre_reg == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pre_reg <= '0;
        end else if (pre_reg == LAST) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_reg + 1'b1;
        end
    end

endmodule

// File: rtl/gifplayer_frame_sequencer.sv
// Fetches per-frame details from the image-details RAM, times the frame delay and
// advances the frame index on the first vsync after the delay has elapsed.
module gifplayer_frame_sequencer #(
    parameter int CLK_HZ     = 50000000,
    parameter int TICK_DIV   = CLK_HZ / 100,
    parameter int IDX_W      = 8,
    parameter int DEFAULT_CS = gifplayer_frame_sequencer_pkg::DEFAULT_CS
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               restart,
    input  logic                               vsync,
    gifplayer_frame_sequencer_if.master        det,
    output logic [15:0]                        img_width,
    output logic [15:0]                        img_height,
    output logic [15:0]                        frame_delay,
    output logic [15:0]                        frame_count,
    output logic [31:0]                        frame_pixels,
    output logic [IDX_W-1:0]                   frame_index,
    output logic                               frame_advance,
    output logic                               details_valid
);

    import gifplayer_frame_sequencer_pkg::*;

    localparam logic [15:0] DFLT_CS = 16'(DEFAULT_CS);

    state_t            state_reg;
    state_t            state_next;
    logic [2:0]        fetch_cnt_reg;
    logic [2:0]        fetch_cnt_next;
    logic              capture_en;
    logic [15:0]       words [4];
    logic [15:0]       delay_reg;
    logic [31:0]       pixels_reg;
    logic [IDX_W-1:0]  index_reg;
    logic [IDX_W-1:0]  index_wrap;
    logic [16:0]       index_inc;
    logic              advance_reg;
    logic [15:0]       cs_cnt_reg;
    logic              tick;
    logic              expire;
    logic              take_vsync;

    gifplayer_cs_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_cs_tick (
        .clk   (clk),
        .reset (reset),
        .clear (state_reg != ST_RUN),
        .tick  (tick)
    );

    // Read latency is one cycle, so word n lands while fetch_cnt == n+1.
    assign capture_en = enable && !restart && (state_reg == ST_FETCH);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_word
            logic [15:0] word_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    word_q <= '0;
                end else if (capture_en && (fetch_cnt_reg == 3'(gi + 1))) begin
                    word_q <= det.det_readdata;
                end
            end
            assign words[gi] = word_q;
        end
    endgenerate

    assign expire     = tick && ((17'(cs_cnt_reg) + 17'd1) == 17'(delay_reg));
    assign index_inc  = 17'(index_reg) + 17'd1;
    assign index_wrap = (index_inc >= {1'b0, words[DET_COUNT]}) ? '0 : index_inc[IDX_W-1:0];
    assign take_vsync = enable && !restart && (state_reg == ST_WAIT_VSYNC) && vsync;

    always_comb begin
        state_next     = state_reg;
        fetch_cnt_next = capture_en ? fetch_cnt_reg + 3'd1 : 3'd0;
        if (!enable) begin
            state_next = ST_IDLE;
        end else if (restart) begin
            state_next = ST_FETCH;
        end else begin
            case (state_reg)
                ST_IDLE:       state_next = ST_FETCH;
                ST_FETCH:      state_next = (fetch_cnt_reg == 3'd4) ? ST_CALC : ST_FETCH;
                ST_CALC:       state_next = (words[DET_COUNT] == 16'd0) ? ST_IDLE : ST_RUN;
                ST_RUN:        state_next = expire ? ST_WAIT_VSYNC : ST_RUN;
                ST_WAIT_VSYNC: state_next = vsync ? ST_ADVANCE : ST_WAIT_VSYNC;
                ST_ADVANCE:    state_next = ST_FETCH;
                default:       state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            fetch_cnt_reg <= 3'd0;
            delay_reg     <= '0;
            pixels_reg    <= '0;
            index_reg     <= '0;
            advance_reg   <= 1'b0;
            cs_cnt_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            fetch_cnt_reg <= fetch_cnt_next;
            advance_reg   <= 1'b0;
            if (restart) begin
                index_reg <= '0;
            end else if (take_vsync) begin
                index_reg   <= index_wrap;
                advance_reg <= 1'b1;
            end
            if (enable && !restart && (state_reg == ST_CALC)) begin
                pixels_reg <= 32'(words[DET_WIDTH]) * 32'(words[DET_HEIGHT]);
                delay_reg  <= delay_or_default(words[DET_DELAY], DFLT_CS);
            end
            if (state_reg != ST_RUN) begin
                cs_cnt_reg <= '0;
            end else if (tick) begin
                cs_cnt_reg <= cs_cnt_reg + 16'd1;
            end
        end
    end

    // The fifth fetch cycle only collects the last word, so the RAM is no longer selected.
    assign det.det_chipselect = enable && (state_reg == ST_FETCH) && (fetch_cnt_reg < 3'd4);
    assign det.det_address    = fetch_cnt_reg[1:0];

    assign img_width     = words[DET_WIDTH];
    assign img_height    = words[DET_HEIGHT];
    assign frame_count   = words[DET_COUNT];
    assign frame_delay   = delay_reg;
    assign frame_pixels  = pixels_reg;
    assign frame_index   = index_reg;
    assign frame_advance = advance_reg;
    assign details_valid = enable && ((state_reg == ST_RUN) || (state_reg == ST_WAIT_VSYNC));

endmodule

// File: tb/tb_gifplayer_frame_sequencer.sv
// Scoreboard bench: stimulus queues expected DUT events, a negedge monitor pops and compares them.
module tb_gifplayer_frame_sequencer;

    localparam int EV_SNAP  = 0;
    localparam int EV_READ  = 1;
    localparam int EV_VALID = 2;
    localparam int EV_ADV   = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
    } ev_t;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        restart;
    logic        vsync;
    logic [15:0] img_width;
    logic [15:0] img_height;
    logic [15:0] frame_delay;
    logic [15:0] frame_count;
    logic [31:0] frame_pixels;
    logic [7:0]  frame_index;
    logic        frame_advance;
    logic        details_valid;

    logic [15:0] mem [4];
    int          cyc;
    int          checks;
    int          errors;
    logic        snap_req;
    logic        valid_prev;
    ev_t         exp_q [$];

    gifplayer_frame_sequencer_if det_bus ();

    gifplayer_frame_sequencer #(
        .TICK_DIV   (4),
        .IDX_W      (8),
        .DEFAULT_CS (10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .restart       (restart),
        .vsync         (vsync),
        .det           (det_bus),
        .img_width     (img_width),
        .img_height    (img_height),
        .frame_delay   (frame_delay),
        .frame_count   (frame_count),
        .frame_pixels  (frame_pixels),
        .frame_index   (frame_index),
        .frame_advance (frame_advance),
        .details_valid (details_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Details RAM model with one cycle of read latency.
    initial det_bus.det_readdata = 16'd0;
    always @(posedge clk) begin
        if (det_bus.det_chipselect) det_bus.det_readdata <= mem[det_bus.det_address];
    end

    function automatic logic [31:0] dvec(input logic cs, input logic vld, input logic adv,
                                         input logic [1:0] addr, input logic [7:0] idx);
        return {19'd0, cs, vld, adv, addr, idx};
    endfunction

    function automatic string kind_name(input int k);
        case (k)
            EV_SNAP:  return "snapshot";
            EV_READ:  return "ram_read";
            EV_VALID: return "details_valid_rise";
            default:  return "frame_advance";
        endcase
    endfunction

    task automatic push(input int kind, input int at, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
        ev_t e;
        e.kind = kind; e.cyc = at; e.a = a; e.b = b; e.c = c; e.d = d;
        exp_q.push_back(e);
    endtask

    // Expected reads of one fetch starting at cycle n, plus the RUN entry if frames exist.
    task automatic expect_frame(input int n, input logic [7:0] idx);
        logic [15:0] dly;
        for (int i = 0; i < 4; i++) push(EV_READ, n + i, 32'(i), 0, 0, 0);
        dly = (mem[2] == 16'd0) ? 16'd10 : mem[2];
        if (mem[3] != 16'd0)
            push(EV_VALID, n + 6, 32'(mem[0]) * 32'(mem[1]), {dly, mem[3]},
                 {mem[0], mem[1]}, dvec(1'b0, 1'b1, 1'b0, 2'd0, idx));
    endtask

    function automatic ev_t observe(input int kind);
        ev_t o;
        o.kind = kind; o.cyc = cyc; o.a = 0; o.b = 0; o.c = 0; o.d = 0;
        if (kind == EV_READ) begin
            o.a = 32'(det_bus.det_address);
        end else if (kind == EV_ADV) begin
            o.d = dvec(det_bus.det_chipselect, details_valid, frame_advance,
                       det_bus.det_address, frame_index);
        end else begin
            o.a = frame_pixels;
            o.b = {frame_delay, frame_count};
            o.c = {img_width, img_height};
            o.d = dvec(det_bus.det_chipselect, details_valid, frame_advance,
                       det_bus.det_address, frame_index);
        end
        return o;
    endfunction

    task automatic check_event(input ev_t o);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s at cyc=%0d a=%h b=%h c=%h d=%h, required none",
                     kind_name(o.kind), o.cyc, o.a, o.b, o.c, o.d);
        end else begin
            e = exp_q.pop_front();
            if (o.kind != e.kind || o.cyc != e.cyc || o.a !== e.a || o.b !== e.b ||
                o.c !== e.c || o.d !== e.d) begin
                errors++;
                $display("FAIL %s got cyc=%0d a=%h b=%h c=%h d=%h, required %s cyc=%0d a=%h b=%h c=%h d=%h",
                         kind_name(o.kind), o.cyc, o.a, o.b, o.c, o.d,
                         kind_name(e.kind), e.cyc, e.a, e.b, e.c, e.d);
            end else begin
                $display("ok %s cyc=%0d a=%h b=%h c=%h d=%h",
                         kind_name(o.kind), o.cyc, o.a, o.b, o.c, o.d);
            end
        end
    endtask

    initial begin
        valid_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (snap_req) check_event(observe(EV_SNAP));
            if (det_bus.det_chipselect === 1'b1) check_event(observe(EV_READ));
            if (details_valid === 1'b1 && !valid_prev) check_event(observe(EV_VALID));
            if (frame_advance === 1'b1) check_event(observe(EV_ADV));
            valid_prev = (details_valid === 1'b1);
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d, required completion", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int e;
        int r;
        checks = 0; errors = 0;
        reset = 1'b1; enable = 1'b0; restart = 1'b0; vsync = 1'b0; snap_req = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = 16'd0;

        // Reset state
        step(1);
        push(EV_SNAP, cyc, 0, 0, 0, 0);
        snap_req = 1'b1; step(1); snap_req = 1'b0; reset = 1'b0;

        // 320x200, delay 3, two frames: fetch, CALC, RUN, expiry after 12 cycles
        mem = '{16'd320, 16'd200, 16'd3, 16'd2};
        step(1);
        e = cyc; enable = 1'b1;
        expect_frame(e + 1, 8'd0);
        r = e + 7;
        wait_until(r + 12); vsync = 1'b1;
        push(EV_ADV, r + 13, 0, 0, 0, dvec(1'b0, 1'b0, 1'b1, 2'd0, 8'd1));
        expect_frame(r + 14, 8'd1);
        step(1); vsync = 1'b0;
        r = r + 20;

        // Enable dropped mid-RUN: IDLE next cycle, index and details held
        wait_until(r + 3); enable = 1'b0;
        push(EV_SNAP, r + 4, 32'd64000, {16'd3, 16'd2}, {16'd320, 16'd200},
             dvec(1'b0, 1'b0, 1'b0, 2'd0, 8'd1));
        wait_until(r + 4); snap_req = 1'b1; step(1); snap_req = 1'b0;

        // Restart at index 1 with a zero delay word: index 0, no advance, fetch from 0
        mem[2] = 16'd0;
        wait_until(r + 6); enable = 1'b1; restart = 1'b1;
        expect_frame(r + 7, 8'd0);
        step(1); restart = 1'b0;
        r = r + 13;

        // Delay 10 cs = 40 cycles; vsync on the expiry cycle is ignored
        wait_until(r + 39); vsync = 1'b1; step(1); vsync = 1'b0;
        wait_until(r + 42); vsync = 1'b1;
        push(EV_ADV, r + 43, 0, 0, 0, dvec(1'b0, 1'b0, 1'b1, 2'd0, 8'd1));
        mem = '{16'd2, 16'd3, 16'd1, 16'd2};
        expect_frame(r + 44, 8'd1);
        step(1); vsync = 1'b0;
        r = r + 50;

        // Index wraps 1 -> 0, then reset in the middle of the refetch
        wait_until(r + 4); vsync = 1'b1;
        push(EV_ADV, r + 5, 0, 0, 0, dvec(1'b0, 1'b0, 1'b1, 2'd0, 8'd0));
        push(EV_READ, r + 6, 32'd0, 0, 0, 0);
        push(EV_READ, r + 7, 32'd1, 0, 0, 0);
        step(1); vsync = 1'b0;
        wait_until(r + 7); reset = 1'b1;
        push(EV_SNAP, r + 8, 0, 0, 0, 0);
        wait_until(r + 8); snap_req = 1'b1; step(1); snap_req = 1'b0;
        reset = 1'b0; enable = 1'b0;

        // frame_count 0: CALC returns to IDLE without ever going valid
        mem = '{16'd5, 16'd5, 16'd5, 16'd0};
        step(1);
        e = cyc; enable = 1'b1;
        expect_frame(e + 1, 8'd0);
        push(EV_SNAP, e + 7, 32'd25, {16'd5, 16'd0}, {16'd5, 16'd5},
             dvec(1'b0, 1'b0, 1'b0, 2'd0, 8'd0));
        wait_until(e + 7); snap_req = 1'b1; step(1); snap_req = 1'b0; enable = 1'b0;

        step(20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got %0d outstanding, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
